ifetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory and the IF stage of the pipelined RV32 core. It owns the fetch PC and issues word-aligned fetch requests over a request/grant and response-valid memory handshake. Returned instructions are buffered together with their PCs in a small FIFO that the IF/ID register drains with a valid/ready handshake. A redirect from the ID stage (taken branch, jal or jalr) flushes the queue, discards in-flight responses and restarts fetch at the target.

---
 rtl/ifetch_queue_if.sv | 31 +++
 rtl/ifetch_queue.sv | 108 ++++++++++
 tb/tb_ifetch_queue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch queue bus: instruction memory request/response,
// IF/ID valid/ready drain and ID-stage redirect.
interface ifetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_valid, if_pc, if_instr,
    input  if_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_valid, if_pc, if_instr,
    output if_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers
// returned words with their PCs, flushes on redirect.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  ifetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] LIMIT = (CW+2)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q [DEPTH];
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  cnt_t        count;
  cnt_t        outstanding;
  cnt_t        discard;
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;

  logic [CW+1:0] credit;
  logic [31:0]   target;
  logic          issue;
  logic          push;
  logic          drop;
  logic          pop;
  logic          rv;

  // Discarded words still hold a slot until they come back.
  assign credit = {2'b00, count}
                + {2'b00, outstanding}
                + {2'b00, discard};

  assign rv     = bus.mem_rvalid;
  assign target = {bus.redirect_pc[31:2], 2'b00};

  assign bus.mem_req  = rst && !bus.redirect_valid
                      && (credit < LIMIT);
  assign bus.mem_addr = fetch_pc;

  assign issue = bus.mem_req && bus.mem_gnt;
  assign drop  = rv && (discard != '0);
  assign push  = rv && (discard == '0)
               && !bus.redirect_valid;

  assign bus.if_valid = (count != '0)
                      && !bus.redirect_valid;
  assign pop          = bus.if_valid && bus.if_ready;

  assign bus.if_pc    = bus.if_valid ? q[rd_ptr].pc    : '0;
  assign bus.if_instr = bus.if_valid ? q[rd_ptr].instr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      discard     <= discard + outstanding - cnt_t'(rv);
      outstanding <= outstanding - cnt_t'(rv);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + cnt_t'(issue)
                   - cnt_t'(rv);
      if (drop) begin
        discard <= discard - cnt_t'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + ptr_t'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q[wr_ptr] <= '{pc: resp_pc, instr: bus.mem_rdata};
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: in-order memory model
// with configurable latency and an expected-pair scoreboard.
module tb_ifetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t pend [$];
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int grants = 0;
  int pops   = 0;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = base + 32'(4 * i);
      e.instr = mword(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: present memory response, sample, scoreboard.
  task automatic tick();
    exp_t e;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mword(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
    #1;
    s_req   = bus.mem_req;
    s_addr  = bus.mem_addr;
    s_valid = bus.if_valid;
    s_pc    = bus.if_pc;
    s_instr = bus.if_instr;
    if (s_req && bus.mem_gnt) begin
      pend.push_back('{cyc + lat, s_addr});
      grants++;
    end
    if (s_valid && bus.if_ready) begin
      chkb("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", s_pc, e.pc);
        chk("sb_instr", s_instr, e.instr);
      end
      pops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;
    bus.mem_gnt        = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    pend.delete();
    exp_q.delete();
    #1;
    chkb("rst_req", bus.mem_req, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chkb("rst_valid", bus.if_valid, 1'b0);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_instr", bus.if_instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    cyc    = 0;
    grants = 0;
  endtask

  task automatic wait_req(output logic [31:0] a, output int n);
    a = '0;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (s_req && bus.mem_gnt) begin
        a = s_addr;
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_pops(input int target, input string tag);
    for (int i = 0; i < 40 && pops < target; i++) begin
      tick();
    end
    chkb(tag, pops >= target, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    int          p0;

    // Streaming from reset, 1-cycle memory
    do_reset();
    lat          = 1;
    bus.if_ready = 1'b1;
    bus.mem_gnt  = 1'b1;
    push_seq(32'h0, 16);
    for (int i = 0; i < 10; i++) begin
      tick();
      chkb("st_req", s_req, 1'b1);
      chk("st_addr", s_addr, 32'(4 * i));
      chkb("st_valid", s_valid, i >= 2);
    end
    chk("st_pops", 32'(pops), 32'd8);

    // Backpressure then back-to-back drain
    do_reset();
    lat          = 1;
    bus.if_ready = 1'b0;
    bus.mem_gnt  = 1'b1;
    push_seq(32'h0, 40);
    repeat (10) tick();
    chk("bp_grants", 32'(grants), 32'd4);
    chkb("bp_req", s_req, 1'b0);
    chkb("bp_valid", s_valid, 1'b1);
    chk("bp_head_pc", s_pc, 32'h0);
    chk("bp_head_instr", s_instr, mword(32'h0));
    bus.if_ready = 1'b1;
    p0 = pops;
    tick();
    chkb("bp_d0_valid", s_valid, 1'b1);
    chkb("bp_d0_req", s_req, 1'b0);
    tick();
    chkb("bp_d1_req", s_req, 1'b1);
    chk("bp_d1_addr", s_addr, 32'h10);
    repeat (8) tick();
    chk("bp_pops", 32'(pops - p0), 32'd10);

    // Redirect with two late responses in flight
    do_reset();
    lat          = 3;
    bus.if_ready = 1'b1;
    bus.mem_gnt  = 1'b1;
    tick();
    tick();
    chk("rd_grants", 32'(grants), 32'd2);
    exp_q.delete();
    push_seq(32'h100, 20);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    chkb("rd_cyc_req", s_req, 1'b0);
    chkb("rd_cyc_valid", s_valid, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    chkb("rd_next_valid", s_valid, 1'b0);
    chkb("rd_next_req", s_req, 1'b0);
    wait_req(a, n);
    chk("rd_addr", a, 32'h100);
    chk("rd_wait", 32'(n), 32'd1);
    wait_pops(pops + 3, "rd_pops");

    // Redirect colliding with rvalid and a pop
    do_reset();
    lat          = 1;
    bus.if_ready = 1'b1;
    bus.mem_gnt  = 1'b1;
    push_seq(32'h0, 16);
    repeat (5) tick();
    chkb("rp_pre_valid", s_valid, 1'b1);
    exp_q.delete();
    push_seq(32'h204, 20);
    p0 = pops;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0206;
    tick();
    chkb("rp_valid", s_valid, 1'b0);
    chk("rp_pc", s_pc, 32'h0);
    bus.redirect_valid = 1'b0;
    wait_req(a, n);
    chk("rp_addr", a, 32'h204);
    chk("rp_wait", 32'(n), 32'd1);
    wait_pops(p0 + 4, "rp_pops");

    // Address wrap at the top of memory
    exp_q.delete();
    push_seq(32'hFFFF_FFFC, 8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    wait_req(a, n);
    chk("wr_addr0", a, 32'hFFFF_FFFC);
    tick();
    chkb("wr_req1", s_req, 1'b1);
    chk("wr_addr1", s_addr, 32'h0);
    wait_pops(pops + 4, "wr_pops");

    // Reset mid-stream with entries queued and in flight
    do_reset();
    lat          = 2;
    bus.if_ready = 1'b0;
    bus.mem_gnt  = 1'b1;
    repeat (4) tick();
    chk("mr_grants", 32'(grants), 32'd4);
    chkb("mr_valid", s_valid, 1'b1);
    chk("mr_pc", s_pc, 32'h0);
    do_reset();
    lat          = 1;
    bus.if_ready = 1'b1;
    bus.mem_gnt  = 1'b1;
    push_seq(32'h0, 16);
    wait_req(a, n);
    chk("mr_addr", a, 32'h0);
    chk("mr_wait", 32'(n), 32'd1);
    wait_pops(pops + 4, "mr_pops");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
